// File: rtl/regfile_writeback_queue.sv
// Purpose: in-order writeback queue feeding the register file write port, with operand forwarding.
// Latency: a result accepted at edge N is written out (reg_write high) during cycle N+1 -> N+2 at the earliest.
// Backpressure: mem_ready/alu_ready drop when the queue is full; loads take priority; wb_stall holds the drain.
module regfile_writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [ADDR_WIDTH-1:0]      alu_dest,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_WIDTH-1:0]      mem_dest,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_ready,
  input  logic                       wb_stall,
  output logic                       reg_write,
  output logic [ADDR_WIDTH-1:0]      write_reg,
  output logic [DATA_WIDTH-1:0]      write_data,
  input  logic [ADDR_WIDTH-1:0]      read_reg_1,
  input  logic [ADDR_WIDTH-1:0]      read_reg_2,
  output logic                       fwd_hit_1,
  output logic [DATA_WIDTH-1:0]      fwd_data_1,
  output logic                       fwd_hit_2,
  output logic [DATA_WIDTH-1:0]      fwd_data_2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entry storage is never reset; validity is tracked purely by head/count.
  logic [ADDR_WIDTH-1:0] dest_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  full;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] in_dest;
  logic [DATA_WIDTH-1:0] in_data;

  // Readiness looks only at the current occupancy, never at a same-cycle pop.
  assign full      = (count == CNT_W'(DEPTH));
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  // Pick the offered result: a load always wins over an ALU result.
  always_comb begin
    in_dest = alu_dest;
    in_data = alu_data;
    if (mem_valid) begin
      in_dest = mem_dest;
      in_data = mem_data;
    end
  end

  // r0 results finish the handshake but are dropped instead of occupying a slot.
  assign accept = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push   = accept && (in_dest != '0);
  assign pop    = (count != '0) && !wb_stall;

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write accepted results into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[tail] <= in_dest;
      data_q[tail] <= in_data;
    end
  end

  // Output register: move the head entry to the register file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (pop) begin
      reg_write  <= 1'b1;
      write_reg  <= dest_q[head];
      write_data <= data_q[head];
    end else begin
      reg_write  <= 1'b0;
    end
  end

  // Scan oldest to youngest so the last match (youngest) overrides earlier ones.
  // The output register is the oldest pending value, the tail the youngest.
  function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [ADDR_WIDTH-1:0] rr);
    logic                  hit;
    logic [DATA_WIDTH-1:0] dat;
    logic [PTR_W-1:0]      idx;
    hit = 1'b0;
    dat = '0;
    idx = '0;
    if (rr != '0) begin
      if (reg_write && (write_reg == rr)) begin
        hit = 1'b1;
        dat = write_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if ((CNT_W'(i) < count) && (dest_q[idx] == rr)) begin
          hit = 1'b1;
          dat = data_q[idx];
        end
      end
    end
    return {hit, dat};
  endfunction

  // Forwarding lookup for both read ports.
  always_comb begin
    {fwd_hit_1, fwd_data_1} = fwd_lookup(read_reg_1);
    {fwd_hit_2, fwd_data_2} = fwd_lookup(read_reg_2);
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        wb_stall;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic        fwd_hit_1;
  logic [31:0] fwd_data_1;
  logic        fwd_hit_2;
  logic [31:0] fwd_data_2;
  logic [2:0]  count;

  int  checks = 0;
  int  errors = 0;
  wb_t exp_q[$];

  regfile_writeback_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
    .fwd_hit_2(fwd_hit_2), .fwd_data_2(fwd_data_2),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((count != 0 || reg_write) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_done", (n < 50), 1);
  endtask

  // Scoreboard monitor: every register file write must match the oldest expected write.
  always @(negedge clk) begin
    wb_t e;
    if (!reset && reg_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got r%0d=%0h expected no write", write_reg, write_data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_reg", write_reg, e.r);
        chk("wb_data", write_data, e.d);
      end
    end
  end

  initial begin
    reset = 1'b1; alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0; wb_stall = 0;
    read_reg_1 = 0; read_reg_2 = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    tick();
    reset = 1'b0;

    // Single ALU result, check latency.
    alu_valid = 1; alu_dest = 3; alu_data = 32'h11;
    exp_q.push_back('{r: 5'd3, d: 32'h11});
    @(negedge clk);
    chk("t1_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    @(negedge clk);
    chk("t1_no_early_write", reg_write, 0);
    chk("t1_count1", count, 1);
    tick();
    @(negedge clk);
    chk("t1_write", reg_write, 1);
    tick();
    @(negedge clk);
    chk("t1_write_done", reg_write, 0);
    chk("t1_count0", count, 0);

    // Load and ALU offered together: load first, ALU held one cycle.
    tick();
    mem_valid = 1; mem_dest = 4; mem_data = 32'hAA;
    alu_valid = 1; alu_dest = 5; alu_data = 32'hBB;
    @(negedge clk);
    chk("t2_alu_blocked", alu_ready, 0);
    chk("t2_mem_ready", mem_ready, 1);
    exp_q.push_back('{r: 5'd4, d: 32'hAA});
    tick();
    mem_valid = 0;
    @(negedge clk);
    chk("t2_alu_ready", alu_ready, 1);
    exp_q.push_back('{r: 5'd5, d: 32'hBB});
    tick();
    alu_valid = 0;
    @(negedge clk);
    chk("t2_first_write", reg_write, 1);
    tick();
    @(negedge clk);
    chk("t2_second_write", reg_write, 1);
    chk("t2_second_reg", write_reg, 5);
    wait_drain();

    // Fill under stall, then drain in order.
    wb_stall = 1;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1; alu_dest = 5'(i); alu_data = 32'h100 + 32'(i);
      exp_q.push_back('{r: 5'(i), d: 32'h100 + 32'(i)});
      @(negedge clk);
      chk("t3_push_ready", alu_ready, 1);
      tick();
    end
    alu_valid = 0;
    @(negedge clk);
    chk("t3_full_count", count, 4);
    chk("t3_full_alu_ready", alu_ready, 0);
    chk("t3_full_mem_ready", mem_ready, 0);
    chk("t3_stalled_no_write", reg_write, 0);
    tick();
    wb_stall = 0;
    alu_valid = 1; alu_dest = 9; alu_data = 32'h99;
    @(negedge clk);
    chk("t3_full_while_draining", alu_ready, 0);
    tick();
    alu_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_drain_write", reg_write, 1);
      chk("t3_drain_count", count, 64'(3 - k));
      tick();
    end
    @(negedge clk);
    chk("t3_drain_end", reg_write, 0);

    // Forwarding: youngest match wins, r0 never hits.
    tick();
    wb_stall = 1;
    alu_valid = 1; alu_dest = 7; alu_data = 32'h1;
    exp_q.push_back('{r: 5'd7, d: 32'h1});
    tick();
    alu_dest = 8; alu_data = 32'h33;
    exp_q.push_back('{r: 5'd8, d: 32'h33});
    tick();
    alu_dest = 7; alu_data = 32'h2;
    exp_q.push_back('{r: 5'd7, d: 32'h2});
    tick();
    alu_valid = 0;
    read_reg_1 = 7; read_reg_2 = 8;
    @(negedge clk);
    chk("t4_hit1", fwd_hit_1, 1);
    chk("t4_data1_youngest", fwd_data_1, 32'h2);
    chk("t4_hit2", fwd_hit_2, 1);
    chk("t4_data2", fwd_data_2, 32'h33);
    read_reg_2 = 0;
    #1;
    chk("t4_r0_hit", fwd_hit_2, 0);
    chk("t4_r0_data", fwd_data_2, 0);
    read_reg_2 = 3;
    #1;
    chk("t4_miss_hit", fwd_hit_2, 0);
    chk("t4_miss_data", fwd_data_2, 0);
    tick();
    wb_stall = 0;
    tick();
    @(negedge clk);
    chk("t4_queue_over_outreg", fwd_data_1, 32'h2);
    tick(); tick();
    @(negedge clk);
    chk("t4_outreg_count", count, 0);
    chk("t4_outreg_write", reg_write, 1);
    chk("t4_outreg_hit", fwd_hit_1, 1);
    chk("t4_outreg_data", fwd_data_1, 32'h2);
    wait_drain();
    @(negedge clk);
    chk("t4_after_drain_hit", fwd_hit_1, 0);
    chk("t4_after_drain_data", fwd_data_1, 0);

    // A result only being offered is not forwarded.
    tick();
    alu_valid = 1; alu_dest = 9; alu_data = 32'h99;
    read_reg_1 = 9;
    #1;
    chk("t4_offered_no_hit", fwd_hit_1, 0);
    exp_q.push_back('{r: 5'd9, d: 32'h99});
    tick();
    alu_valid = 0;
    #1;
    chk("t4_queued_hit", fwd_hit_1, 1);
    chk("t4_queued_data", fwd_data_1, 32'h99);
    wait_drain();

    // r0 destination: handshake only.
    tick();
    alu_valid = 1; alu_dest = 0; alu_data = 32'hFF;
    @(negedge clk);
    chk("t5_r0_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    @(negedge clk);
    chk("t5_r0_count", count, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("t5_r0_no_write", reg_write, 0);
    end

    // Reset mid-operation discards everything queued.
    tick();
    wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_dest = 5'(10 + i); alu_data = 32'hA0 + 32'(i);
      exp_q.push_back('{r: 5'(10 + i), d: 32'hA0 + 32'(i)});
      tick();
    end
    alu_valid = 0;
    @(negedge clk);
    chk("t6_pre_reset_count", count, 3);
    tick();
    reset = 1;
    exp_q.delete();
    tick();
    reset = 0;
    read_reg_1 = 10; read_reg_2 = 11;
    @(negedge clk);
    chk("t6_post_reset_count", count, 0);
    chk("t6_post_reset_write", reg_write, 0);
    chk("t6_post_reset_hit1", fwd_hit_1, 0);
    chk("t6_post_reset_hit2", fwd_hit_2, 0);
    tick();
    wb_stall = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("t6_no_write_after_reset", reg_write, 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
